// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: widths, ALU op codes, FSM states, payloads.
package ex_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PCW  = 48;
    localparam int unsigned ITER = 32;
    localparam int unsigned CNTW = $clog2(ITER);
    localparam int unsigned OPW  = 4;

    localparam logic [OPW-1:0] ALU_ADD   = 4'd0;
    localparam logic [OPW-1:0] ALU_SUB   = 4'd1;
    localparam logic [OPW-1:0] ALU_AND   = 4'd2;
    localparam logic [OPW-1:0] ALU_OR    = 4'd3;
    localparam logic [OPW-1:0] ALU_XOR   = 4'd4;
    localparam logic [OPW-1:0] ALU_SLL   = 4'd5;
    localparam logic [OPW-1:0] ALU_SRL   = 4'd6;
    localparam logic [OPW-1:0] ALU_SRA   = 4'd7;
    localparam logic [OPW-1:0] ALU_SLT   = 4'd8;
    localparam logic [OPW-1:0] ALU_SLTU  = 4'd9;
    localparam logic [OPW-1:0] ALU_MUL   = 4'd10;
    localparam logic [OPW-1:0] ALU_DIVU  = 4'd11;
    localparam logic [OPW-1:0] ALU_REMU  = 4'd12;
    localparam logic [OPW-1:0] ALU_PASSB = 4'd13;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ex_state_t;

    // Control fields that ride along with an instruction into EX/MEM
    typedef struct packed {
        logic [2:0]     flags_mem;
        logic [1:0]     flags_wb;
        logic [PCW-1:0] pc1;
        logic [4:0]     rd;
    } ex_ctl_t;

    function automatic logic is_multi(input logic [OPW-1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative engine: one shift-add (MUL) or restoring-divide (DIVU/REMU) step per cycle.
module ex_muldiv
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done_c,
    output logic [XLEN-1:0] result_c
);

    // acc: product accumulator / partial remainder
    // x:   shifted multiplicand / dividend-to-quotient shifter
    // y:   shifted multiplier / divisor
    logic [CNTW-1:0] cnt_q;
    logic [OPW-1:0]  op_q;
    logic [XLEN-1:0] acc_q, x_q, y_q;
    logic [XLEN-1:0] acc_d, x_d, y_d;
    logic [XLEN:0]   rem_sh_c, diff_c;

    // Next-step datapath; a divisor of zero naturally yields all-ones quotient and remainder = dividend
    always_comb begin
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        rem_sh_c = '0;
        diff_c   = '0;
        if (op_q == ALU_MUL) begin
            acc_d = acc_q + (y_q[0] ? x_q : '0);
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
        end else begin
            rem_sh_c = {acc_q, x_q[XLEN-1]};
            diff_c   = rem_sh_c - {1'b0, y_q};
            if (!diff_c[XLEN]) begin
                acc_d = diff_c[XLEN-1:0];
                x_d   = {x_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = rem_sh_c[XLEN-1:0];
                x_d   = {x_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Final-step detection and result selection
    always_comb begin
        done_c   = busy && (cnt_q == CNTW'(ITER - 1));
        result_c = (op_q == ALU_DIVU) ? x_d : acc_d;
    end

    // Operand capture and per-cycle iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt_q <= '0;
            op_q  <= '0;
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt_q <= '0;
            op_q  <= op;
            acc_q <= '0;
            x_q   <= a;
            y_q   <= b;
        end else if (busy) begin
            if (abort || done_c) begin
                busy  <= 1'b0;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNTW'(1);
                acc_q <= acc_d;
                x_q   <= x_d;
                y_q   <= y_d;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, multi-cycle op sequencing and the EX/MEM register.
module ex_stage
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] dataOne,
    input  logic [XLEN-1:0] dataTwo,
    input  logic [XLEN-1:0] immediate,
    input  logic            src_imm,
    input  logic [3:0]      flagsALU,
    input  logic [2:0]      flagsMEM,
    input  logic [1:0]      flagsWB,
    input  logic [PCW-1:0]  pc1,
    input  logic [4:0]      rd_dir,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic [XLEN-1:0] store_data,
    output logic [2:0]      flagsMEM_out,
    output logic [1:0]      flagsWB_out,
    output logic [PCW-1:0]  pc1_out,
    output logic [4:0]      rd_out
);

    ex_state_t       state_q, state_d;
    logic [XLEN-1:0] opb_c, alu_c;
    ex_ctl_t         cur_ctl_c, cap_ctl_q, wb_ctl_c;
    logic [XLEN-1:0] cap_store_q, wb_res_c, wb_store_c;
    logic            start_c, wb_load_c;
    logic            md_busy, md_done_c;
    logic [XLEN-1:0] md_result_c;

    // Operand B select and control bundle of the incoming instruction
    always_comb begin
        opb_c               = src_imm ? immediate : dataTwo;
        cur_ctl_c.flags_mem = flagsMEM;
        cur_ctl_c.flags_wb  = flagsWB;
        cur_ctl_c.pc1       = pc1;
        cur_ctl_c.rd        = rd_dir;
    end

    // Single-cycle ALU; multi-cycle and reserved codes produce 0 here
    always_comb begin
        alu_c = '0;
        case (flagsALU)
            ALU_ADD:   alu_c = dataOne + opb_c;
            ALU_SUB:   alu_c = dataOne - opb_c;
            ALU_AND:   alu_c = dataOne & opb_c;
            ALU_OR:    alu_c = dataOne | opb_c;
            ALU_XOR:   alu_c = dataOne ^ opb_c;
            ALU_SLL:   alu_c = dataOne << opb_c[4:0];
            ALU_SRL:   alu_c = dataOne >> opb_c[4:0];
            ALU_SRA:   alu_c = XLEN'($signed(dataOne) >>> opb_c[4:0]);
            ALU_SLT:   alu_c = XLEN'($signed(dataOne) < $signed(opb_c));
            ALU_SLTU:  alu_c = XLEN'(dataOne < opb_c);
            ALU_PASSB: alu_c = opb_c;
            default:   alu_c = '0;
        endcase
    end

    ex_muldiv u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_c),
        .abort    (flush),
        .op       (flagsALU),
        .a        (dataOne),
        .b        (opb_c),
        .busy     (md_busy),
        .done_c   (md_done_c),
        .result_c (md_result_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state, stall and EX/MEM load selection
    always_comb begin
        state_d    = state_q;
        start_c    = 1'b0;
        stall      = 1'b0;
        wb_load_c  = 1'b0;
        wb_res_c   = alu_c;
        wb_ctl_c   = cur_ctl_c;
        wb_store_c = dataTwo;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    if (is_multi(flagsALU)) begin
                        start_c = 1'b1;
                        stall   = 1'b1;
                        state_d = ST_BUSY;
                    end else begin
                        wb_load_c = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                stall = !flush;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (md_done_c) begin
                    wb_load_c  = 1'b1;
                    wb_res_c   = md_result_c;
                    wb_ctl_c   = cap_ctl_q;
                    wb_store_c = cap_store_q;
                    state_d    = ST_IDLE;
                end else if (!md_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hold the control fields and store data of the instruction under iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_ctl_q   <= '0;
            cap_store_q <= '0;
        end else if (start_c) begin
            cap_ctl_q   <= cur_ctl_c;
            cap_store_q <= dataTwo;
        end
    end

    // EX/MEM register: load a result or a bubble every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            alu_result   <= '0;
            zero         <= 1'b0;
            store_data   <= '0;
            flagsMEM_out <= '0;
            flagsWB_out  <= '0;
            pc1_out      <= '0;
            rd_out       <= '0;
        end else if (wb_load_c) begin
            out_valid    <= 1'b1;
            alu_result   <= wb_res_c;
            zero         <= (wb_res_c == '0);
            store_data   <= wb_store_c;
            flagsMEM_out <= wb_ctl_c.flags_mem;
            flagsWB_out  <= wb_ctl_c.flags_wb;
            pc1_out      <= wb_ctl_c.pc1;
            rd_out       <= wb_ctl_c.rd;
        end else begin
            out_valid    <= 1'b0;
            flagsMEM_out <= '0;
            flagsWB_out  <= '0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors, expectations queued at issue, checked by a monitor.
module tb_ex_stage;
    import ex_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, flush, src_imm;
    logic [31:0]     dataOne, dataTwo, immediate;
    logic [3:0]      flagsALU;
    logic [2:0]      flagsMEM;
    logic [1:0]      flagsWB;
    logic [47:0]     pc1;
    logic [4:0]      rd_dir;
    logic            stall, out_valid, zero;
    logic [31:0]     alu_result, store_data;
    logic [2:0]      flagsMEM_out;
    logic [1:0]      flagsWB_out;
    logic [47:0]     pc1_out;
    logic [4:0]      rd_out;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic [47:0] pc1;
        logic [4:0]  rd;
        logic [31:0] store;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .flush        (flush),
        .dataOne      (dataOne),
        .dataTwo      (dataTwo),
        .immediate    (immediate),
        .src_imm      (src_imm),
        .flagsALU     (flagsALU),
        .flagsMEM     (flagsMEM),
        .flagsWB      (flagsWB),
        .pc1          (pc1),
        .rd_dir       (rd_dir),
        .stall        (stall),
        .out_valid    (out_valid),
        .alu_result   (alu_result),
        .zero         (zero),
        .store_data   (store_data),
        .flagsMEM_out (flagsMEM_out),
        .flagsWB_out  (flagsWB_out),
        .pc1_out      (pc1_out),
        .rd_out       (rd_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_alu_result", 64'(alu_result), 64'(mon_e.res));
                check("sb_zero", 64'(zero), 64'(mon_e.zero));
                check("sb_flagsMEM", 64'(flagsMEM_out), 64'(mon_e.mem));
                check("sb_flagsWB", 64'(flagsWB_out), 64'(mon_e.wb));
                check("sb_pc1", 64'(pc1_out), 64'(mon_e.pc1));
                check("sb_rd", 64'(rd_out), 64'(mon_e.rd));
                check("sb_store_data", 64'(store_data), 64'(mon_e.store));
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [2:0] mem,
                         input logic [1:0] wb, input logic [47:0] pc, input logic [4:0] rd);
        flagsALU  = op;
        dataOne   = a;
        dataTwo   = b;
        immediate = imm;
        src_imm   = src;
        flagsMEM  = mem;
        flagsWB   = wb;
        pc1       = pc;
        rd_dir    = rd;
        in_valid  = 1'b1;
        flush     = 1'b0;
    endtask

    // Issue one instruction (called just after a rising edge); returns after it is consumed
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [2:0] mem,
                         input logic [1:0] wb, input logic [47:0] pc, input logic [4:0] rd,
                         input logic [31:0] exp_res);
        exp_t e;
        int   cnt;
        int   guard;
        drive(op, a, b, imm, src, mem, wb, pc, rd);
        e.res   = exp_res;
        e.zero  = (exp_res == 32'd0);
        e.mem   = mem;
        e.wb    = wb;
        e.pc1   = pc;
        e.rd    = rd;
        e.store = b;
        sb.push_back(e);
        if (op >= 4'd10 && op <= 4'd12) begin
            cnt   = 0;
            guard = 0;
            do begin
                @(negedge clk);
                if (stall) cnt++;
                @(posedge clk);
                #1;
                guard++;
            end while (!out_valid && guard < 100);
            check("multi_stall_cycles", 64'(cnt), 64'd33);
        end else begin
            @(negedge clk);
            check("single_stall_low", 64'(stall), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd0, 48'd0, 5'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_alu_result", 64'(alu_result), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // Non-zero EX/MEM contents, then reset in the middle of a MUL
        issue(ALU_SUB, 32'd5, 32'd7, 32'd0, 1'b0, 3'b001, 2'b01, 48'h1, 5'd3, 32'hFFFF_FFFE);
        drive(ALU_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 3'b100, 2'b11, 48'h55, 5'd9);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_alu_result", 64'(alu_result), 64'd0);
        check("midrst_zero", 64'(zero), 64'd0);
        check("midrst_store_data", 64'(store_data), 64'd0);
        check("midrst_flags", 64'({flagsMEM_out, flagsWB_out}), 64'd0);
        check("midrst_pc1_rd", 64'({pc1_out, rd_out}), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        issue(ALU_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 3'b000, 2'b10, 48'h10, 5'd1, 32'd7);

        // Single-cycle ALU sweep
        issue(ALU_SUB,  32'd5,         32'd7,         32'd0,         1'b0, 3'b000, 2'b01, 48'h11, 5'd2, 32'hFFFF_FFFE);
        issue(ALU_SRA,  32'h8000_0000, 32'd4,         32'd0,         1'b0, 3'b000, 2'b01, 48'h12, 5'd3, 32'hF800_0000);
        issue(ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 3'b000, 2'b01, 48'h13, 5'd4, 32'd1);
        issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 3'b000, 2'b01, 48'h14, 5'd5, 32'd0);
        issue(ALU_ADD,  32'd1,         32'h55,        32'hFFFF_FFFF, 1'b1, 3'b010, 2'b01, 48'h15, 5'd6, 32'd0);
        issue(ALU_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0,         1'b0, 3'b000, 2'b01, 48'h16, 5'd7, 32'h00F0_00F0);
        issue(ALU_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0,         1'b0, 3'b000, 2'b01, 48'h17, 5'd8, 32'hFFF0_FFF0);
        issue(ALU_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0,         1'b0, 3'b000, 2'b01, 48'h18, 5'd9, 32'hFF00_FF00);
        issue(ALU_SLL,  32'd1,         32'h3F,        32'd0,         1'b0, 3'b000, 2'b01, 48'h19, 5'd10, 32'h8000_0000);
        issue(ALU_SRL,  32'h8000_0000, 32'd4,         32'd0,         1'b0, 3'b000, 2'b01, 48'h1A, 5'd11, 32'h0800_0000);
        issue(ALU_PASSB, 32'd9,        32'h1234_5678, 32'd0,         1'b0, 3'b001, 2'b01, 48'h1B, 5'd12, 32'h1234_5678);
        issue(4'd15,    32'd9,         32'd9,         32'd0,         1'b0, 3'b000, 2'b01, 48'h1C, 5'd13, 32'd0);

        // Multi-cycle ops issued back to back (MUL immediately followed by DIVU)
        issue(ALU_MUL,  32'h0001_0003, 32'h0002_0005, 32'd0, 1'b0, 3'b010, 2'b01, 48'hABCD_0000_1234, 5'd7, 32'h000B_000F);
        issue(ALU_DIVU, 32'd100,       32'd7,         32'd0, 1'b0, 3'b000, 2'b10, 48'h20, 5'd14, 32'd14);
        issue(ALU_REMU, 32'd100,       32'd7,         32'd0, 1'b0, 3'b000, 2'b10, 48'h21, 5'd15, 32'd2);
        issue(ALU_DIVU, 32'h1234_5678, 32'd0,         32'd0, 1'b0, 3'b000, 2'b10, 48'h22, 5'd16, 32'hFFFF_FFFF);
        issue(ALU_REMU, 32'd9,         32'd0,         32'd0, 1'b0, 3'b000, 2'b10, 48'h23, 5'd17, 32'd9);
        issue(ALU_DIVU, 32'h8000_0000, 32'd3,         32'd0, 1'b0, 3'b000, 2'b10, 48'h24, 5'd18, 32'h2AAA_AAAA);
        issue(ALU_REMU, 32'hFFFF_FFFF, 32'd0,         32'h10, 1'b1, 3'b000, 2'b10, 48'h25, 5'd19, 32'd15);
        idle(1);

        // Flush during BUSY cycle 5: no result, stall drops with flush
        drive(ALU_MUL, 32'd3, 32'd5, 32'd0, 1'b0, 3'b000, 2'b11, 48'h30, 5'd20);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        #1;
        check("flush_stall_same_cycle", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("flush_back_to_idle", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        issue(ALU_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 3'b000, 2'b10, 48'h31, 5'd21, 32'd30);

        // Bubbles: in_valid low, then flush with in_valid high
        in_valid = 1'b0;
        flagsWB  = 2'b11;
        flagsMEM = 3'b111;
        @(posedge clk);
        #1;
        check("bubble_out_valid", 64'(out_valid), 64'd0);
        check("bubble_flagsWB", 64'(flagsWB_out), 64'd0);
        check("bubble_flagsMEM", 64'(flagsMEM_out), 64'd0);
        check("bubble_result_hold", 64'(alu_result), 64'd30);
        drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 3'b011, 2'b11, 48'h40, 5'd22);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_single_out_valid", 64'(out_valid), 64'd0);
        check("flush_single_flagsWB", 64'(flagsWB_out), 64'd0);
        idle(3);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. It consumes the ID/EX pipeline register outputs and computes the ALU result, including iterative 32-cycle MUL/DIVU/REMU.
- Results are registered into the EX/MEM boundary, so this block also acts as the EX/MEM register.
- It drives `stall` back to the hazard unit to freeze IF/ID and ID/EX while a multi-cycle operation runs.

Parameters:
- XLEN, 32, datapath width.
- PCW, 48, program-counter width carried down the pipe.
- ITER, 32, iterations per multi-cycle op. Must equal XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX holds a real instruction (0 = bubble)
- flush  in  1  kill the instruction in EX (branch/exception)
- dataOne  in  XLEN  operand A
- dataTwo  in  XLEN  operand B / store data
- immediate  in  XLEN  sign-extended immediate
- src_imm  in  1  1: operand B = immediate
- flagsALU  in  4  ALU op code
- flagsMEM  in  3  memory control, passed through
- flagsWB  in  2  writeback control, passed through
- pc1  in  PCW  PC+1, passed through
- rd_dir  in  5  destination register
- stall  out  1  hold upstream pipeline registers
- out_valid  out  1  EX/MEM holds a real instruction
- alu_result  out  XLEN  result
- zero  out  1  alu_result == 0
- store_data  out  XLEN  dataTwo captured with the instruction
- flagsMEM_out  out  3  registered
- flagsWB_out  out  2  registered
- pc1_out  out  PCW  registered
- rd_out  out  5  registered

Behaviour:
- Reset: every output register is 0 (out_valid=0, zero=0, flags=0). FSM goes to IDLE, counter=0. Reset asserted mid-operation aborts it immediately; no result is ever produced for that operation.
- flagsALU encoding, shared package:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount = B[4:0])
  - 8 SLT (signed), 9 SLTU
  - 10 MUL (low 32 bits of product), 11 DIVU, 12 REMU
  - 13 PASSB
  - 14–15 reserved → result 0
- Arithmetic wraps modulo 2^32. No overflow flag.
- Single-cycle ops, in IDLE with in_valid=1 and flush=0:
  - Result and passthrough fields load at the next edge with out_valid=1. Latency 1, stall=0.
- Bubble (in_valid=0, or flush=1, in IDLE):
  - Next edge loads out_valid=0, flagsMEM_out=0, flagsWB_out=0. Other outputs are don't-care but deterministic: hold.
- FSM states: IDLE, BUSY.
  - IDLE→BUSY: in_valid & ~flush & op∈{10,11,12}. At that edge, capture A, B (after the src_imm mux), op, and passthrough fields; set counter=0. EX/MEM loads a bubble.
  - BUSY:
    - One shift-add (MUL) or restoring-divide (DIVU/REMU) step per cycle; counter increments.
    - On the step with counter==ITER-1, EX/MEM loads the result with out_valid=1 and captured fields; FSM→IDLE.
    - Other BUSY cycles load a bubble.
  - stall (combinational) = (IDLE & in_valid & ~flush & multi-op) | BUSY. stall is therefore high for exactly ITER+1 = 33 consecutive cycles per multi-cycle op.
  - Upstream holds ID/EX stable while stall=1. EX ignores in_valid while BUSY.
  - flush in BUSY: abort → IDLE at next edge, EX/MEM loads a bubble, stall drops the same cycle flush is seen.
- Divide by zero:
  - DIVU → 0xFFFFFFFF.
  - REMU → dividend. Still takes the full 32 cycles.
- zero is computed from the value being loaded into alu_result and registered with it.
- Back-to-back multi-cycle ops: IDLE is re-entered for at least one cycle between them. The held ID/EX instruction is accepted on that IDLE cycle.

Decomposition:
- Package ex_pkg: ALU op localparams (ALU_ADD … ALU_PASSB), FSM state encoding, XLEN/PCW defaults.
- Sub-module: ex_muldiv. Holds the iterative multiply/divide engine with start/op/a/b inputs and busy/done/result outputs. ex_stage holds the single-cycle ALU, the FSM glue and the EX/MEM register.

Test Plan:
- Reset mid-MUL: assert rst_n=0 at BUSY cycle 10 → all outputs 0, stall=0. Release rst_n, then ADD 3+4 → alu_result=7, out_valid=1 one cycle later.
- ALU sweep: SUB 5−7 → 0xFFFFFFFE, zero=0. SRA 0x80000000>>4 → 0xF8000000. SLT −1<1 → 1. SLTU −1<1 → 0. ADD with src_imm=1, imm=0xFFFFFFFF, A=1 → 0, zero=1.
- MUL 0x0001_0003 × 0x0002_0005 → stall high 33 cycles, single out_valid pulse with alu_result=0x000B_000F. flagsWB/rd/pc1 match the captured values.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU x/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Flush at BUSY cycle 5 → no out_valid for that op, stall=0 the same cycle, next ADD completes normally.
- Bubble: in_valid=0 with flagsWB=2'b11 → out_valid=0, flagsWB_out=0. MUL followed immediately by DIVU → both results correct, one IDLE cycle between the stall windows.
